// File: rtl/dca_lpixm_responder_pkg.sv
// Shared definitions for the LPIXM SRAM responder: response codes, link field
// layout helpers and the burst-tracking state encoding.
package dca_lpixm_responder_pkg;

    localparam logic [1:0] RESP_OK     = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } burst_state_e;

    // Request beat layout (LSB first): wstrb, wdata, addr, wr.
    function automatic int strb_w(input int dw);
        return dw / 8;
    endfunction

    function automatic int qdata_w(input int aw, input int dw);
        return 1 + aw + dw + dw / 8;
    endfunction

    function automatic int q_wdata_lsb(input int dw);
        return dw / 8;
    endfunction

    function automatic int q_addr_lsb(input int dw);
        return dw + dw / 8;
    endfunction

    function automatic int q_wr_bit(input int aw, input int dw);
        return aw + dw + dw / 8;
    endfunction

    // Response layout: {rdata, resp[1:0]}.
    function automatic int ydata_w(input int dw);
        return dw + 2;
    endfunction

    localparam int Y_RESP_LSB  = 0;
    localparam int Y_RDATA_LSB = 2;

endpackage

// File: rtl/dca_lpixm_resp_fifo.sv
// Synchronous response FIFO with occupancy count; pointer/count state only is
// reset, the storage array is left uninitialised.
module dca_lpixm_resp_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clear,
    input  logic                     i_push,
    input  logic [W-1:0]             i_wdata,
    input  logic                     i_pop,
    output logic [W-1:0]             o_rdata,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [PW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign w_pop  = i_pop & (r_count != '0);
    assign w_push = i_push & ((r_count != (PW+1)'(DEPTH)) | w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push & ~i_clear) r_mem[r_wptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (PW+1)'(DEPTH));
    assign o_count = r_count;

endmodule

// File: rtl/dca_lpixm_sram_responder.sv
// LPIXM responder: executes sxq request beats on a 1-cycle SRAM port and returns
// ordered responses on sxy. Optional range/alignment check: DCA_LPIXM_RESPONDER_ADDR_CHECK_EN.
module dca_lpixm_sram_responder
    import dca_lpixm_responder_pkg::*;
#(
    parameter int                 BW_ADDR    = 32,
    parameter int                 BW_DATA    = 32,
    parameter int                 SRAM_AW    = 10,
    parameter logic [BW_ADDR-1:0] BASE_ADDR  = '0,
    parameter int                 RESP_DEPTH = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   clear,
    input  logic                                   enable,
    output logic                                   busy,
    output logic [1:0]                             sxqdready,
    input  logic                                   sxqvalid,
    input  logic                                   sxqhint,
    input  logic                                   sxqlast,
    input  logic                                   sxqafy,
    input  logic [qdata_w(BW_ADDR, BW_DATA)-1:0]   sxqdata,
    input  logic [1:0]                             sxydready,
    output logic                                   sxyvalid,
    output logic                                   sxyhint,
    output logic                                   sxylast,
    output logic [ydata_w(BW_DATA)-1:0]            sxydata,
    output logic                                   sram_cs,
    output logic                                   sram_we,
    output logic [SRAM_AW-1:0]                     sram_addr,
    output logic [strb_w(BW_DATA)-1:0]             sram_wstrb,
    output logic [BW_DATA-1:0]                     sram_wdata,
    input  logic [BW_DATA-1:0]                     sram_rdata
);
    localparam int BW_STRB = strb_w(BW_DATA);
    localparam int LG_STRB = $clog2(BW_STRB);
    localparam int CW      = $clog2(RESP_DEPTH) + 1;
    localparam int FE      = BW_DATA + 3;

    logic                  w_en;
    logic                  w_wr;
    logic [BW_ADDR-1:0]    w_addr;
    logic [BW_ADDR-1:0]    w_off;
    logic [BW_DATA-1:0]    w_wdata;
    logic [BW_STRB-1:0]    w_wstrb;
    logic                  w_err;
    logic                  w_owes;
    logic [CW:0]           w_cnt;
    logic                  w_rdy0;
    logic                  w_rdy1;
    logic                  w_accept;
    logic                  w_access;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_valid;
    logic [FE-1:0]         w_push_data;
    logic [FE-1:0]         w_head;
    logic                  w_empty;
    logic                  w_full;
    logic [CW-1:0]         w_fifo_count;
    logic                  w_unused;

    logic                  r_inflight;
    logic                  r_wr;
    logic                  r_last;
    logic                  r_err;
    burst_state_e          r_state;
    burst_state_e          w_state_nxt;

    assign w_en    = enable & ~clear & ~rst;
    assign w_wr    = sxqdata[q_wr_bit(BW_ADDR, BW_DATA)];
    assign w_addr  = sxqdata[q_addr_lsb(BW_DATA) +: BW_ADDR];
    assign w_wdata = sxqdata[q_wdata_lsb(BW_DATA) +: BW_DATA];
    assign w_wstrb = sxqdata[BW_STRB-1:0];
    assign w_off   = w_addr - BASE_ADDR;

`ifdef DCA_LPIXM_RESPONDER_ADDR_CHECK_EN
    logic w_in_range;
    logic w_aligned;
    assign w_in_range = (w_addr >= BASE_ADDR) && ((w_off >> (SRAM_AW + LG_STRB)) == '0);
    assign w_aligned  = ((w_addr & BW_ADDR'(BW_STRB - 1)) == '0);
    assign w_err      = ~(w_in_range & w_aligned);
`else
    assign w_err      = 1'b0;
`endif

    // Error beats always answer, even unacked writes, so they need a credit.
    assign w_owes   = ~sxqhint & (~w_wr | sxqafy | w_err);
    assign w_cnt    = (CW+1)'(w_fifo_count) + (CW+1)'(r_inflight);
    assign w_rdy0   = w_en & (w_cnt < (CW+1)'(RESP_DEPTH));
    assign w_rdy1   = w_en & ((w_cnt + (CW+1)'(1)) < (CW+1)'(RESP_DEPTH));
    assign w_accept = w_en & sxqvalid & (w_rdy0 | ~w_owes);
    assign w_access = w_accept & ~sxqhint & ~w_err;

    assign sxqdready  = {w_rdy1, w_rdy0};
    assign sram_cs    = w_access;
    assign sram_we    = w_access & w_wr;
    assign sram_addr  = w_access ? SRAM_AW'(w_off >> LG_STRB) : '0;
    assign sram_wstrb = (w_access & w_wr) ? w_wstrb : '0;
    assign sram_wdata = (w_access & w_wr) ? w_wdata : '0;

    // A stalled enable keeps the beat in flight; the macro holds rdata while cs=0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight <= 1'b0;
            r_wr       <= 1'b0;
            r_last     <= 1'b0;
            r_err      <= 1'b0;
        end else if (clear) begin
            r_inflight <= 1'b0;
        end else if (enable) begin
            r_inflight <= w_accept & w_owes;
            if (w_accept & w_owes) begin
                r_wr   <= w_wr;
                r_last <= sxqlast;
                r_err  <= w_err;
            end
        end
    end

    assign w_push      = r_inflight & enable & ~clear;
    assign w_push_data = {(r_wr | r_err) ? '0 : sram_rdata,
                          r_err ? RESP_SLVERR : RESP_OK,
                          r_last};

    assign w_valid = ~w_empty & w_en;
    assign w_pop   = w_valid & sxydready[0];

    dca_lpixm_resp_fifo #(
        .W     (FE),
        .DEPTH (RESP_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_clear (clear),
        .i_push  (w_push),
        .i_wdata (w_push_data),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_count (w_fifo_count)
    );

    assign sxyvalid = w_valid;
    assign sxydata  = w_valid ? w_head[FE-1:1] : '0;
    assign sxylast  = w_valid & w_head[0];
    assign sxyhint  = ~clear & ~rst & (r_inflight | ~w_empty);
    assign busy     = ~clear & ~rst & (r_inflight | ~w_empty | (r_state == ST_BURST));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Hint beats are advisory and do not advance burst tracking.
    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = ST_IDLE;
        end else if (w_accept & ~sxqhint) begin
            case (r_state)
                ST_IDLE:  if (!sxqlast) w_state_nxt = ST_BURST;
                ST_BURST: if (sxqlast)  w_state_nxt = ST_IDLE;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign w_unused = ^{sxydready[1], w_full};

endmodule

// File: tb/tb_dca_lpixm_sram_responder.sv
// Scoreboard bench for dca_lpixm_sram_responder: directed beats push expected
// responses into a queue, a negedge monitor pops and compares on every handshake.
module tb_dca_lpixm_sram_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        enable;
    logic        busy;
    logic [1:0]  sxqdready;
    logic        sxqvalid;
    logic        sxqhint;
    logic        sxqlast;
    logic        sxqafy;
    logic [68:0] sxqdata;
    logic [1:0]  sxydready;
    logic        sxyvalid;
    logic        sxyhint;
    logic        sxylast;
    logic [33:0] sxydata;
    logic        sram_cs;
    logic        sram_we;
    logic [9:0]  sram_addr;
    logic [3:0]  sram_wstrb;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    logic [31:0] mem [1024];
    logic [34:0] exp_q [$];
    int          n_vec  = 0;
    int          n_miss = 0;

    always #5 clk = ~clk;

    dca_lpixm_sram_responder dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .enable     (enable),
        .busy       (busy),
        .sxqdready  (sxqdready),
        .sxqvalid   (sxqvalid),
        .sxqhint    (sxqhint),
        .sxqlast    (sxqlast),
        .sxqafy     (sxqafy),
        .sxqdata    (sxqdata),
        .sxydready  (sxydready),
        .sxyvalid   (sxyvalid),
        .sxyhint    (sxyhint),
        .sxylast    (sxylast),
        .sxydata    (sxydata),
        .sram_cs    (sram_cs),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wstrb (sram_wstrb),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    // 1-cycle-latency SRAM macro with byte enables
    always @(posedge clk) begin
        if (sram_cs && !sram_we) sram_rdata <= mem[sram_addr];
        if (sram_cs && sram_we)
            for (int b = 0; b < 4; b++)
                if (sram_wstrb[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
    end

    always @(negedge clk) begin
        if (!rst && sxyvalid && sxydready[0]) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_miss++;
                $display("FAIL resp_unexpected: got %h, required none", {sxydata, sxylast});
            end else begin
                logic [34:0] e;
                e = exp_q.pop_front();
                if ({sxydata, sxylast} !== e) begin
                    n_miss++;
                    $display("FAIL resp_data: got {rdata,resp,last}=%h, required %h", {sxydata, sxylast}, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic set_beat(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic afy, input logic last, input logic hint);
        sxqvalid = 1'b1;
        sxqhint  = hint;
        sxqlast  = last;
        sxqafy   = afy;
        sxqdata  = {wr, addr, data, strb};
    endtask

    // Issue one beat, wait (bounded) for acceptance, record the expected response.
    task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic afy, input logic last, input logic hint,
                        input logic [31:0] exp_rd, input logic [1:0] exp_resp);
        logic owes;
        bit   done;
        owes = !hint && (!wr || afy || exp_resp != 2'd0);
        done = 0;
        set_beat(wr, addr, data, strb, afy, last, hint);
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (sxqdready[0] || !owes) begin
                done = 1;
                if (owes) exp_q.push_back({exp_rd, exp_resp, last});
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            n_vec++;
            n_miss++;
            $display("FAIL accept_timeout: addr %h not accepted, required acceptance", addr);
        end
        sxqvalid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 | i;
        sram_rdata = '0;
        rst = 1'b1; clear = 1'b0; enable = 1'b1;
        sxqvalid = 1'b0; sxqhint = 1'b0; sxqlast = 1'b0; sxqafy = 1'b0; sxqdata = '0;
        sxydready = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {sxqdready, sxyvalid, sxyhint, busy, sram_cs, sxydata}, 64'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_reset", {62'd0, sxqdready}, 64'd3);

        // Acked write 0xDEADBEEF @0x10 -> SRAM word 4 in the accept cycle
        set_beat(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk("wr_sram", {sram_cs, sram_we, sram_addr, sram_wstrb, sram_wdata},
            {16'd0, 1'b1, 1'b1, 10'd4, 4'hF, 32'hDEAD_BEEF});
        exp_q.push_back({32'h0, 2'd0, 1'b1});
        @(posedge clk); #1;
        sxqvalid = 1'b0;
        drain("wr_ack_drain");
        repeat (2) @(posedge clk);
        #1;

        // Read back with latency check
        send(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 2'd0);
        chk("rd_inflight", {62'd0, sxyvalid, sxyhint}, 64'd1);
        @(posedge clk); #1;
        chk("rd_valid_1cyc", {29'd0, sxyvalid, sxydata}, {29'd0, 1'b1, 32'hDEAD_BEEF, 2'd0});
        drain("rd_drain");

        // 8-beat read burst against a stalled initiator
        sxydready = 2'b00;
        for (int k = 0; k < 4; k++) begin
            set_beat(1'b0, 32'h20 + 32'(4*k), 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            chk("burst_ready", {62'd0, sxqdready}, (k == 3) ? 64'd1 : 64'd3);
            exp_q.push_back({32'hA500_0008 + 32'(k), 2'd0, 1'b0});
            @(posedge clk); #1;
        end
        sxqvalid = 1'b0;
        @(negedge clk);
        chk("burst_full_ready", {62'd0, sxqdready}, 64'd0);
        chk("burst_busy", {63'd0, busy}, 64'd1);
        @(posedge clk); #1;
        // Unacked write and hint need no credit while the FIFO is full
        set_beat(1'b1, 32'h44, 32'hCAFE_F00D, 4'h3, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("nocredit_wr", {sram_cs, sram_we, sram_addr, sram_wstrb}, {48'd0, 1'b1, 1'b1, 10'd17, 4'h3});
        @(posedge clk); #1;
        set_beat(1'b0, 32'h48, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        sxqvalid = 1'b0;
        @(negedge clk);
        chk("burst_hold", {sxyvalid, sxylast, sxqdready, sxydata}, {28'd0, 1'b1, 1'b0, 2'd0, 32'hA500_0008, 2'd0});
        sxydready = 2'b01;
        @(posedge clk); #1;
        for (int k = 4; k < 8; k++)
            send(1'b0, 32'h20 + 32'(4*k), 32'h0, 4'h0, 1'b0, (k == 7), 1'b0, 32'hA500_0008 + 32'(k), 2'd0);
        drain("burst_drain");
        chk("burst_idle", {61'd0, busy, sxqdready}, 64'd3);

        // Unacked write and hint: no response, nothing in flight
        send(1'b1, 32'h40, 32'h1234_5678, 4'hF, 1'b0, 1'b1, 1'b0, 32'h0, 2'd0);
        chk("noack_wr_quiet", {60'd0, sxyhint, busy, sxqdready}, 64'd3);
        send(1'b0, 32'h50, 32'h0, 4'h0, 1'b0, 1'b1, 1'b1, 32'h0, 2'd0);
        chk("hint_quiet", {60'd0, sxyhint, busy, sxqdready}, 64'd3);
        repeat (2) @(posedge clk);
        #1;
        chk("noack_no_resp", {63'd0, sxyvalid}, 64'd0);
        send(1'b0, 32'h40, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 32'h1234_5678, 2'd0);
        send(1'b0, 32'h44, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 32'hA500_F00D, 2'd0);
        drain("noack_drain");

        // clear with 2 queued and 1 in flight, inside an open burst
        sxydready = 2'b00;
        send(1'b0, 32'h00, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'hA500_0000, 2'd0);
        send(1'b0, 32'h04, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'hA500_0001, 2'd0);
        send(1'b0, 32'h08, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'hA500_0002, 2'd0);
        chk("pre_clear", {61'd0, busy, sxyhint, sxyvalid}, 64'd7);
        clear = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("clear_cycle", {58'd0, sxyvalid, sxyhint, busy, sxqdready, sram_cs}, 64'd0);
        @(posedge clk); #1;
        clear = 1'b0;
        #1;
        chk("post_clear", {61'd0, sxyvalid, busy, sxyhint}, 64'd0);
        sxydready = 2'b01;
        repeat (3) @(posedge clk);
        #1;
        chk("post_clear_quiet", {61'd0, sxyvalid, sxqdready}, 64'd3);

`ifdef DCA_LPIXM_RESPONDER_ADDR_CHECK_EN
        set_beat(1'b0, 32'h3, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("misaligned_cs", {63'd0, sram_cs}, 64'd0);
        exp_q.push_back({32'h0, 2'd2, 1'b1});
        @(posedge clk); #1;
        set_beat(1'b0, 32'h1000, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("range_cs", {63'd0, sram_cs}, 64'd0);
        exp_q.push_back({32'h0, 2'd2, 1'b1});
        @(posedge clk); #1;
        sxqvalid = 1'b0;
`else
        // Out-of-range address wraps modulo the SRAM size: 0x1010 -> word 4
        send(1'b0, 32'h1010, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 2'd0);
`endif
        drain("final_drain");
        chk("final_idle", {63'd0, busy}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
